// File: rtl/rvc_asap_pkg.sv
// rtl/rvc_asap_pkg.sv - shared types and constants for the rvc_asap core
package rvc_asap_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } t_fetch_state;

  // addi x0,x0,0
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic word_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rvc_next_pc_5pl.sv
// rtl/rvc_next_pc_5pl.sv - next fetch address priority mux with wrap and alignment check
module rvc_next_pc_5pl
  import rvc_asap_pkg::*;
(
  input  t_fetch_state state,
  input  logic [31:0]  pc,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  input  logic         fault_clr,
  input  logic [31:0]  resume_pc,
  output logic [31:0]  next_pc,
  output logic         br_misalign,
  output logic         resume_misalign
);

  logic [31:0] pc_plus4;

  // 32-bit add wraps FFFF_FFFC -> 0 on its own
  assign pc_plus4        = pc + 32'd4;
  assign br_misalign     = word_misaligned(br_target);
  assign resume_misalign = word_misaligned(resume_pc);

  always_comb begin
    next_pc = pc;
    case (state)
      FETCH_BOOT: begin
        if (!stall) next_pc = pc_plus4;
      end
      FETCH_RUN: begin
        if (br_taken) begin
          // a bad target is never fetched; the address freezes for the fault
          if (!br_misalign) next_pc = br_target;
        end else if (!stall) begin
          next_pc = pc_plus4;
        end
      end
      FETCH_FAULT: begin
        if (fault_clr && !resume_misalign) next_pc = resume_pc;
      end
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/rvc_fetch_5pl.sv
// rtl/rvc_fetch_5pl.sv - 5-stage rvc_asap instruction fetch; RVC_FETCH_PERF_EN adds perf counters
module rvc_fetch_5pl
  import rvc_asap_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        StallQ101H,
  input  logic        BranchTakenQ102H,
  input  logic [31:0] BranchTargetQ102H,
  input  logic        FaultClr,
  input  logic [31:0] FaultResumePc,
  output logic [31:0] PcQ100H,
  input  logic [31:0] InstructionQ101H,
  output logic [31:0] PcQ101H,
  output logic [31:0] PcPlus4Q101H,
  output logic [31:0] InstrOutQ101H,
  output logic        InstrValidQ101H,
  output logic        MisalignFaultQ101H
`ifdef RVC_FETCH_PERF_EN
  ,
  output logic [31:0] PerfFetchCnt,
  output logic [31:0] PerfStallCnt,
  output logic [31:0] PerfFlushCnt
`endif
);

  t_fetch_state state_q, state_d;
  logic [31:0]  pc100_q, pc100_d;
  logic [31:0]  pc101_q;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic         load101;
  logic         br_misalign, resume_misalign;

  rvc_next_pc_5pl u_next_pc (
    .state           (state_q),
    .pc              (pc100_q),
    .stall           (StallQ101H),
    .br_taken        (BranchTakenQ102H),
    .br_target       (BranchTargetQ102H),
    .fault_clr       (FaultClr),
    .resume_pc       (FaultResumePc),
    .next_pc         (pc100_d),
    .br_misalign     (br_misalign),
    .resume_misalign (resume_misalign)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    fault_d = fault_q;
    load101 = 1'b0;
    case (state_q)
      FETCH_BOOT: begin
        // the word at pc100 arrives next cycle, so Q101H is valid from then on
        state_d = FETCH_RUN;
        load101 = 1'b1;
        valid_d = 1'b1;
      end
      FETCH_RUN: begin
        if (BranchTakenQ102H) begin
          load101 = 1'b1;
          valid_d = 1'b0;
          if (br_misalign) begin
            state_d = FETCH_FAULT;
            fault_d = 1'b1;
          end
        end else if (!StallQ101H) begin
          load101 = 1'b1;
          valid_d = 1'b1;
        end
      end
      FETCH_FAULT: begin
        valid_d = 1'b0;
        if (FaultClr && !resume_misalign) begin
          state_d = FETCH_BOOT;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = FETCH_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q <= FETCH_BOOT;
      pc100_q <= RESET_PC;
      pc101_q <= RESET_PC;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc100_q <= pc100_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      if (load101) pc101_q <= pc100_q;
    end
  end

  assign PcQ100H            = pc100_q;
  assign PcQ101H            = pc101_q;
  assign PcPlus4Q101H       = pc101_q + 32'd4;
  // the redirect cycle's own instruction is squashed before the valid register updates
  assign InstrValidQ101H    = valid_q & ~BranchTakenQ102H;
  assign InstrOutQ101H      = InstrValidQ101H ? InstructionQ101H : NOP_INSTR;
  assign MisalignFaultQ101H = fault_q;

`ifdef RVC_FETCH_PERF_EN
  logic fetch_ev, stall_ev, flush_ev;

  assign fetch_ev = InstrValidQ101H & ~StallQ101H;
  assign stall_ev = StallQ101H & (state_q == FETCH_RUN);
  assign flush_ev = BranchTakenQ102H & ~br_misalign & (state_q == FETCH_RUN);

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      PerfFetchCnt <= 32'd0;
      PerfStallCnt <= 32'd0;
      PerfFlushCnt <= 32'd0;
    end else begin
      if (fetch_ev && (PerfFetchCnt != 32'hFFFF_FFFF)) PerfFetchCnt <= PerfFetchCnt + 32'd1;
      if (stall_ev && (PerfStallCnt != 32'hFFFF_FFFF)) PerfStallCnt <= PerfStallCnt + 32'd1;
      if (flush_ev && (PerfFlushCnt != 32'hFFFF_FFFF)) PerfFlushCnt <= PerfFlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvc_fetch_5pl.sv
// tb/tb_rvc_fetch_5pl.sv - self-checking bench for rvc_fetch_5pl
module tb_rvc_fetch_5pl;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        Clock;
  logic        Rst;
  logic        StallQ101H;
  logic        BranchTakenQ102H;
  logic [31:0] BranchTargetQ102H;
  logic        FaultClr;
  logic [31:0] FaultResumePc;
  logic [31:0] PcQ100H;
  logic [31:0] InstructionQ101H;
  logic [31:0] PcQ101H;
  logic [31:0] PcPlus4Q101H;
  logic [31:0] InstrOutQ101H;
  logic        InstrValidQ101H;
  logic        MisalignFaultQ101H;
`ifdef RVC_FETCH_PERF_EN
  logic [31:0] PerfFetchCnt;
  logic [31:0] PerfStallCnt;
  logic [31:0] PerfFlushCnt;
`endif

  rvc_fetch_5pl dut (
    .Clock              (Clock),
    .Rst                (Rst),
    .StallQ101H         (StallQ101H),
    .BranchTakenQ102H   (BranchTakenQ102H),
    .BranchTargetQ102H  (BranchTargetQ102H),
    .FaultClr           (FaultClr),
    .FaultResumePc      (FaultResumePc),
    .PcQ100H            (PcQ100H),
    .InstructionQ101H   (InstructionQ101H),
    .PcQ101H            (PcQ101H),
    .PcPlus4Q101H       (PcPlus4Q101H),
    .InstrOutQ101H      (InstrOutQ101H),
    .InstrValidQ101H    (InstrValidQ101H),
    .MisalignFaultQ101H (MisalignFaultQ101H)
`ifdef RVC_FETCH_PERF_EN
    ,
    .PerfFetchCnt       (PerfFetchCnt),
    .PerfStallCnt       (PerfStallCnt),
    .PerfFlushCnt       (PerfFlushCnt)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[29:0], 2'b11} ^ 32'h1234_0000;
  endfunction

  // synchronous-read memory; its read enable follows the Q101H load so a stalled word stays put
  always @(posedge Clock)
    if (!(StallQ101H && !BranchTakenQ102H)) InstructionQ101H <= instr_at(PcQ100H);

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        clr;
    logic [31:0] rpc;
    logic [31:0] e100;
    logic [31:0] e101;
    logic        ev;
    logic        ef;
  } vec_t;

  typedef struct {
    logic [31:0] pc100;
    logic [31:0] pc101;
    logic [31:0] plus4;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mkv(input logic s, input logic b, input logic [31:0] t,
                               input logic c, input logic [31:0] r,
                               input logic [31:0] e100, input logic [31:0] e101,
                               input logic ev, input logic ef);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.clr = c; v.rpc = r;
    v.e100 = e100; v.e101 = e101; v.ev = ev; v.ef = ef;
    return v;
  endfunction

  function automatic exp_t mke(input logic [31:0] p100, input logic [31:0] p101,
                               input logic v, input logic f);
    exp_t e;
    e.pc100 = p100; e.pc101 = p101; e.plus4 = p101 + 32'd4;
    e.instr = v ? instr_at(p101) : NOPW;
    e.valid = v; e.fault = f;
    return e;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d] scoreboard empty got 1 expected 0", tag, idx);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".pc100"}, idx, PcQ100H, e.pc100);
    chk({tag, ".pc101"}, idx, PcQ101H, e.pc101);
    chk({tag, ".plus4"}, idx, PcPlus4Q101H, e.plus4);
    chk({tag, ".instr"}, idx, InstrOutQ101H, e.instr);
    chk({tag, ".valid"}, idx, {31'd0, InstrValidQ101H}, {31'd0, e.valid});
    chk({tag, ".fault"}, idx, {31'd0, MisalignFaultQ101H}, {31'd0, e.fault});
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic c, input logic [31:0] r);
    StallQ101H = s; BranchTakenQ102H = b; BranchTargetQ102H = t;
    FaultClr = c; FaultResumePc = r;
  endtask

  initial begin
    // free run, 3-cycle stall, redirect beating stall, misalign fault + recovery, wrap
    vecs.push_back(mkv(0,0,0,0,0,            32'h0,        32'h0,        0,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h4,        32'h0,        1,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h8,        32'h4,        1,0));
    vecs.push_back(mkv(1,0,0,0,0,            32'hC,        32'h8,        1,0));
    vecs.push_back(mkv(1,0,0,0,0,            32'hC,        32'h8,        1,0));
    vecs.push_back(mkv(1,0,0,0,0,            32'hC,        32'h8,        1,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'hC,        32'h8,        1,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h10,       32'hC,        1,0));
    vecs.push_back(mkv(1,1,32'h40,0,0,       32'h14,       32'h10,       0,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h40,       32'h14,       0,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h44,       32'h40,       1,0));
    vecs.push_back(mkv(0,1,32'h42,0,0,       32'h48,       32'h44,       0,0));
    vecs.push_back(mkv(1,1,32'h100,0,0,      32'h48,       32'h48,       0,1));
    vecs.push_back(mkv(0,0,0,1,32'h81,       32'h48,       32'h48,       0,1));
    vecs.push_back(mkv(0,0,0,1,32'h80,       32'h48,       32'h48,       0,1));
    vecs.push_back(mkv(0,0,0,0,0,            32'h80,       32'h48,       0,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h84,       32'h80,       1,0));
    vecs.push_back(mkv(0,1,32'hFFFF_FFF8,0,0,32'h88,       32'h84,       0,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'hFFFF_FFF8,32'h88,       0,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'hFFFF_FFFC,32'hFFFF_FFF8,1,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h0,        32'hFFFF_FFFC,1,0));
    vecs.push_back(mkv(0,0,0,0,0,            32'h4,        32'h0,        1,0));

    Rst = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge Clock);
    #6;
    exp_q.push_back(mke(32'h0, 32'h0, 0, 0));
    sb_check("reset", 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clock);
      #1;
      if (i == 0) Rst = 1'b1;
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].clr, vecs[i].rpc);
      exp_q.push_back(mke(vecs[i].e100, vecs[i].e101, vecs[i].ev, vecs[i].ef));
      #4;
      sb_check("vec", i);
    end

    // async reset while a stall and a redirect are both pending
    @(posedge Clock);
    #1;
    drive(1, 1, 32'h200, 0, 32'h0);
    #2;
    Rst = 1'b0;
    #2;
    exp_q.push_back(mke(32'h0, 32'h0, 0, 0));
    sb_check("midrst", 0);
`ifdef RVC_FETCH_PERF_EN
    chk("perf_fetch", 0, PerfFetchCnt, 32'd0);
    chk("perf_stall", 0, PerfStallCnt, 32'd0);
    chk("perf_flush", 0, PerfFlushCnt, 32'd0);
`endif

    @(posedge Clock);
    #1;
    Rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
    exp_q.push_back(mke(32'h0, 32'h0, 0, 0));
    #4;
    sb_check("restart", 0);
    @(posedge Clock);
    #1;
    exp_q.push_back(mke(32'h4, 32'h0, 1, 0));
    #4;
    sb_check("restart", 1);
    @(posedge Clock);
    #1;
    exp_q.push_back(mke(32'h8, 32'h4, 1, 0));
    #4;
    sb_check("restart", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
